// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: instruction fields and ALU flags in,
// datapath strobes and selects out.
interface control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_load;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state;

    // Control unit side
    modport master (
        input  opcode, funct, zero, overflow,
        output pc_load, pc_source, iord, mem_write, ir_write, mdr_write, ab_write,
               aluout_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, trap, trap_cause, state
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_load, pc_source, iord, mem_write, ir_write, mdr_write, ab_write,
               aluout_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, trap, trap_cause, state
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit. Moore FSM with a 3-bit wait counter
// stretching FETCH and LW_READ over the memory latency; halts in TRAP on
// illegal instructions or signed overflow.
module control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input logic            clk,
    input logic            reset,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StRExec   = 4'd3,
        StRWb     = 4'd4,
        StIExec   = 4'd5,
        StIWb     = 4'd6,
        StMemAddr = 4'd7,
        StLwRead  = 4'd8,
        StLwWb    = 4'd9,
        StSwWrite = 4'd10,
        StBeq     = 4'd11,
        StJump    = 4'd12,
        StTrap    = 4'd15
    } state_e;

    localparam logic [2:0] FetchLast = 3'(MEM_WAIT);
    localparam logic [2:0] LwLast    = 3'(MEM_WAIT - 1);

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;

    localparam logic [1:0] CauseIllegal  = 2'b01;
    localparam logic [1:0] CauseOverflow = 2'b10;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    // funct and the lw/sw choice are captured in DECODE so later states never
    // look at the instruction register again.
    logic [5:0] funct_q, funct_d;
    logic       is_sw_q, is_sw_d;

    // State, wait counter and captured decode information
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= 3'd0;
            cause_q <= 2'b00;
            funct_q <= 6'h00;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            funct_q <= funct_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Next-state, dispatch and trap-cause capture
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        funct_d = funct_q;
        is_sw_d = is_sw_q;
        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (cnt_q == FetchLast) state_d = StDecode;
            end
            StDecode: begin
                funct_d = bus.funct;
                is_sw_d = (bus.opcode == 6'h2B);
                case (bus.opcode)
                    6'h00: begin
                        if (bus.funct == FnAdd || bus.funct == FnSub || bus.funct == FnAnd) begin
                            state_d = StRExec;
                        end else begin
                            state_d = StTrap;
                            cause_d = CauseIllegal;
                        end
                    end
                    6'h08:        state_d = StIExec;
                    6'h23, 6'h2B: state_d = StMemAddr;
                    6'h04:        state_d = StBeq;
                    6'h02:        state_d = StJump;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StRExec: begin
                // Logical AND cannot overflow, so its flag is ignored
                if (bus.overflow && funct_q != FnAnd) begin
                    state_d = StTrap;
                    cause_d = CauseOverflow;
                end else begin
                    state_d = StRWb;
                end
            end
            StIExec: begin
                if (bus.overflow) begin
                    state_d = StTrap;
                    cause_d = CauseOverflow;
                end else begin
                    state_d = StIWb;
                end
            end
            StMemAddr: state_d = is_sw_q ? StSwWrite : StLwRead;
            StLwRead: begin
                if (cnt_q == LwLast) state_d = StLwWb;
            end
            StRWb, StIWb, StLwWb, StSwWrite, StBeq, StJump: state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StReset;
        endcase

        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if (state_q == StFetch || state_q == StLwRead) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = 3'd0;
        end
    end

    // Moore output decode; only BEQ's pc_load follows an input (zero)
    always_comb begin
        bus.pc_load      = 1'b0;
        bus.pc_source    = 2'b00;
        bus.iord         = 1'b0;
        bus.mem_write    = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mdr_write    = 1'b0;
        bus.ab_write     = 1'b0;
        bus.aluout_write = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.alu_op       = 3'b000;
        bus.trap         = 1'b0;
        bus.trap_cause   = 2'b00;
        unique case (state_q)
            StFetch: begin
                if (cnt_q == FetchLast) begin
                    bus.ir_write  = 1'b1;
                    bus.pc_load   = 1'b1;
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 3'b001;
                end
            end
            StDecode: begin
                bus.ab_write     = 1'b1;
                bus.aluout_write = 1'b1;
                bus.alu_src_a    = 1'b1;
                bus.alu_src_b    = 2'b11;
                bus.alu_op       = 3'b001;
            end
            StRExec: begin
                bus.aluout_write = 1'b1;
                case (funct_q)
                    FnSub:   bus.alu_op = 3'b010;
                    FnAnd:   bus.alu_op = 3'b011;
                    default: bus.alu_op = 3'b001;
                endcase
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StIExec, StMemAddr: begin
                bus.alu_src_b    = 2'b10;
                bus.alu_op       = 3'b001;
                bus.aluout_write = 1'b1;
            end
            StIWb: bus.reg_write = 1'b1;
            StLwRead: begin
                bus.iord      = 1'b1;
                bus.mdr_write = (cnt_q == LwLast);
            end
            StLwWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StSwWrite: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            StBeq: begin
                bus.alu_op    = 3'b010;
                bus.pc_source = 2'b01;
                bus.pc_load   = bus.zero;
            end
            StJump: begin
                bus.pc_load   = 1'b1;
                bus.pc_source = 2'b10;
            end
            StTrap: begin
                bus.trap       = 1'b1;
                bus.trap_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: MEM_WAIT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; forces the RESET state.
REQ-005 opcode  input  6  instruction bits 31:26 from the instruction register.
REQ-006 funct  input  6  instruction bits 5:0.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 overflow  input  1  ALU overflow flag.
REQ-009 pc_load  output  1  PC register load enable.
REQ-010 pc_source  output  2  PC source select: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 iord  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-012 mem_write  output  1  memory write strobe.
REQ-013 ir_write  output  1  instruction register load.
REQ-014 mdr_write  output  1  memory data register load.
REQ-015 ab_write  output  1  A/B operand register load.
REQ-016 aluout_write  output  1  ALUOut register load.
REQ-017 reg_write  output  1  register file write enable.
REQ-018 reg_dst  output  1  write register select: 0 rt, 1 rd.
REQ-019 mem_to_reg  output  1  write data select: 0 ALUOut, 1 MDR.
REQ-020 alu_src_a  output  1  ALU A select: 0 register A, 1 PC.
REQ-021 alu_src_b  output  2  ALU B select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
REQ-022 alu_op  output  3  ALU function: 001 add, 010 sub, 011 and.
REQ-023 trap  output  1  processor halted.
REQ-024 trap_cause  output  2  halt cause: 01 illegal instruction, 10 arithmetic overflow.
REQ-025 state  output  4  current state encoding.

Function
REQ-026 All outputs SHALL be Moore outputs, decoded from the state and the wait counter only.
REQ-027 Any output not listed for a state SHALL be 0 in that state.
REQ-028 State encodings: RESET=0, FETCH=1, DECODE=2, R_EXEC=3, R_WB=4, I_EXEC=5, I_WB=6, MEM_ADDR=7, LW_READ=8, LW_WB=9, SW_WRITE=10, BEQ=11, JUMP=12, TRAP=15.
REQ-029 RESET SHALL go to FETCH on the next edge.
REQ-030 FETCH SHALL last MEM_WAIT+1 cycles, counted by a 3-bit wait counter cleared on state entry, with iord=0 in every cycle.
REQ-031 In the final FETCH cycle, ir_write=1 and pc_load=1 with alu_src_a=1, alu_src_b=01, alu_op=001 and pc_source=00; the next state SHALL be DECODE.
REQ-032 DECODE SHALL assert ab_write=1 and aluout_write=1 with alu_src_a=1, alu_src_b=11 and alu_op=001, so that ALUOut receives the branch target.
REQ-033 DECODE SHALL dispatch on opcode as follows: 0x00 to R_EXEC when funct is 0x20, 0x22 or 0x24, otherwise to TRAP with cause 01.
REQ-034 DECODE dispatch, continued: 0x08 to I_EXEC; 0x23 and 0x2B to MEM_ADDR; 0x04 to BEQ; 0x02 to JUMP; any other opcode to TRAP with cause 01.
REQ-035 R_EXEC SHALL drive alu_src_a=0, alu_src_b=00 and aluout_write=1, with alu_op 001, 010 or 011 for funct 0x20, 0x22 or 0x24.
REQ-036 R_EXEC SHALL go to TRAP with cause 10 if overflow=1 and funct is not 0x24, otherwise to R_WB.
REQ-037 R_WB SHALL assert reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-038 I_EXEC SHALL drive alu_src_b=10, alu_op=001 and aluout_write=1, going to TRAP with cause 10 if overflow=1, otherwise to I_WB.
REQ-039 I_WB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-040 MEM_ADDR SHALL drive alu_src_b=10, alu_op=001 and aluout_write=1, going to LW_READ for opcode 0x23 and to SW_WRITE for 0x2B; overflow is ignored.
REQ-041 LW_READ SHALL last MEM_WAIT cycles with iord=1, assert mdr_write=1 in its last cycle, then go to LW_WB.
REQ-042 LW_WB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-043 SW_WRITE SHALL assert iord=1 and mem_write=1 for exactly one cycle, then go to FETCH.
REQ-044 BEQ SHALL drive alu_src_a=0, alu_src_b=00, alu_op=010, pc_source=01 and pc_load=zero; zero is the only input-dependent output; the next state SHALL be FETCH.
REQ-045 JUMP SHALL assert pc_load=1 with pc_source=10, then go to FETCH.
REQ-046 TRAP SHALL be absorbing: trap=1, trap_cause held at its entry value, and every write or load strobe held at 0 until reset.
REQ-047 Opcode and funct SHALL be sampled only in DECODE and R_EXEC.

Reset
REQ-048 Reset asserted at any time, including mid-FETCH, mid-LW_READ or in TRAP, SHALL immediately force state=RESET, clear the wait counter, and drive all outputs to 0.

Verification
REQ-049 Reset release with MEM_WAIT=2 -> state sequence 0,1,1,1,2; ir_write=1 and pc_load=1 only in the third FETCH cycle.
REQ-050 add rd (opcode 0x00, funct 0x20), overflow=0 -> states 2,3,4,1; reg_write=1 with reg_dst=1 in R_WB; total 6 cycles from FETCH entry.
REQ-051 lw (opcode 0x23) with MEM_WAIT=3 -> MEM_ADDR, then LW_READ x3 with mdr_write only in the last cycle, then LW_WB with mem_to_reg=1.
REQ-052 sw (opcode 0x2B) -> mem_write high for exactly one cycle with iord=1; beq with zero=0 -> pc_load=0; beq with zero=1 -> pc_load=1 and pc_source=01.
REQ-053 addi (opcode 0x08) with overflow=1 in I_EXEC -> TRAP, trap_cause=10, reg_write never asserted; opcode 0x3F -> TRAP with trap_cause=01.
REQ-054 Reset pulsed during LW_READ and again in TRAP -> outputs 0 asynchronously (before the next edge), then normal FETCH resumes.
